// File: rtl/vdp1_cmd_seq_pkg.sv
// Shared VDP1 command-sequencer package.
// Holds the command-table layout, the per-word load masks, the opcode and
// jump-mode constants, and the sequencer state encoding.
package vdp1_cmd_seq_pkg;

    typedef struct packed {
        logic       end_f;
        logic [2:0] jp;
        logic [3:0] zp;
        logic [1:0] rsv;
        logic [1:0] dir;
        logic [3:0] comm;
    } CMDCTRL_t;

    typedef logic [15:0] CMDLINK_t;
    typedef logic [15:0] CMDPMOD_t;
    typedef logic [15:0] CMDCOLR_t;
    typedef logic [15:0] CMDSRCA_t;
    typedef logic [15:0] CMDSIZE_t;
    typedef logic [15:0] CMDCOORD_t;
    typedef logic [15:0] CMDGRDA_t;

    // Word 0 sits in the most significant bits, word 15 in the least.
    typedef struct packed {
        CMDCTRL_t  ctrl;
        CMDLINK_t  link;
        CMDPMOD_t  pmod;
        CMDCOLR_t  colr;
        CMDSRCA_t  srca;
        CMDSIZE_t  size;
        CMDCOORD_t xa;
        CMDCOORD_t ya;
        CMDCOORD_t xb;
        CMDCOORD_t yb;
        CMDCOORD_t xc;
        CMDCOORD_t yc;
        CMDCOORD_t xd;
        CMDCOORD_t yd;
        CMDGRDA_t  grda;
        logic [15:0] unused;
    } CMDTBL_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH_CTRL,
        SEQ_FETCH_LINK,
        SEQ_FETCH_BODY,
        SEQ_DISPATCH,
        SEQ_NEXT,
        SEQ_END
    } SEQ_STATE_t;

    localparam logic [15:0] CMDCTRL_MASK   = 16'hFF3F;
    localparam logic [15:0] CMDLINK_MASK   = 16'hFFFC;
    localparam logic [15:0] CMDPMOD_MASK   = 16'h9FFF;
    localparam logic [15:0] CMDCOLR_MASK   = 16'hFFFF;
    localparam logic [15:0] CMDSRCA_MASK   = 16'hFFFC;
    localparam logic [15:0] CMDSIZE_MASK   = 16'h3FFF;
    localparam logic [15:0] CMDCOORD_MASK  = 16'hFFFF;
    localparam logic [15:0] CMDGRDA_MASK   = 16'hFFFC;
    localparam logic [15:0] CMDUNUSED_MASK = 16'h0000;

    localparam logic [3:0] CMD_NSPR   = 4'h0;
    localparam logic [3:0] CMD_SSPR   = 4'h1;
    localparam logic [3:0] CMD_DSPR   = 4'h2;
    localparam logic [3:0] CMD_POLY   = 4'h4;
    localparam logic [3:0] CMD_PLIN   = 4'h5;
    localparam logic [3:0] CMD_LINE   = 4'h6;
    localparam logic [3:0] CMD_SCLIP  = 4'h8;
    localparam logic [3:0] CMD_UCLIP  = 4'h9;
    localparam logic [3:0] CMD_LCOORD = 4'hA;

    localparam logic [1:0] JP_NEXT   = 2'd0;
    localparam logic [1:0] JP_ASSIGN = 2'd1;
    localparam logic [1:0] JP_CALL   = 2'd2;
    localparam logic [1:0] JP_RETURN = 2'd3;

    // Load mask for table word idx.
    function automatic logic [15:0] cmd_word_mask(input logic [3:0] idx);
        case (idx)
            4'd0:    return CMDCTRL_MASK;
            4'd1:    return CMDLINK_MASK;
            4'd2:    return CMDPMOD_MASK;
            4'd3:    return CMDCOLR_MASK;
            4'd4:    return CMDSRCA_MASK;
            4'd5:    return CMDSIZE_MASK;
            4'd14:   return CMDGRDA_MASK;
            4'd15:   return CMDUNUSED_MASK;
            default: return CMDCOORD_MASK;
        endcase
    endfunction

    // Opcodes that are handed to the draw engine; all others are no-ops.
    function automatic logic cmd_is_drawable(input logic [3:0] comm);
        case (comm)
            CMD_NSPR, CMD_SSPR, CMD_DSPR, CMD_POLY, CMD_PLIN, CMD_LINE,
            CMD_SCLIP, CMD_UCLIP, CMD_LCOORD: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vdp1_cmd_addr.sv
// Next-table-address selection for the VDP1 command sequencer.
// Combinational: jump mode, link, current address and return stack in,
// next address and stack push/pop strobes out. Arithmetic wraps at 2^18.
module vdp1_cmd_addr
    import vdp1_cmd_seq_pkg::*;
(
    input  logic [1:0]  i_jp,
    input  logic [15:0] i_link,
    input  logic [17:0] i_cur,
    input  logic [17:0] i_stk,
    input  logic        i_stk_vld,
    output logic [17:0] o_next,
    output logic [17:0] o_seq,
    output logic        o_push,
    output logic        o_pop
);

    logic [17:0] w_link_addr;

    assign o_seq       = i_cur + 18'd16;
    // Link is a byte address / 8 with the low two bits dropped.
    assign w_link_addr = {i_link[15:2], 4'b0000};

    // Pick the next table address and the stack action for this jump mode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_next = o_seq;
        o_push = 1'b0;
        o_pop  = 1'b0;
        case (i_jp)
            JP_ASSIGN: o_next = w_link_addr;
            JP_CALL: begin
                o_next = w_link_addr;
                o_push = 1'b1;
            end
            JP_RETURN: begin
                if (i_stk_vld) begin
                    o_next = i_stk;
                    o_pop  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vdp1_cmd_seq.sv
// VDP1 command-list sequencer.
// Walks the command tables from VRAM word 0, masks and latches each table,
// resolves jumps, hands drawable commands to the draw engine and keeps
// CEF/BEF/COPR/LOPR. Optional macro VDP1_CMD_WDOG_EN adds a per-frame
// table-count watchdog that forces the list end at WDOG_MAX fetches.
module vdp1_cmd_seq
    import vdp1_cmd_seq_pkg::*;
#(
    parameter logic [15:0] WDOG_MAX = 16'hFFFF
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CE,
    input  logic         START,
    input  logic         ABORT,
    output logic [17:0]  VRAM_A,
    output logic         VRAM_RD,
    input  logic [15:0]  VRAM_D,
    input  logic         VRAM_RDY,
    output logic         CMD_VALID,
    output logic [255:0] CMD_TBL,
    input  logic         CMD_ACK,
    output logic [15:0]  COPR,
    output logic [15:0]  LOPR,
    output logic         CEF,
    output logic         BEF,
    output logic         BUSY
);

    SEQ_STATE_t   r_state;
    logic [17:0]  r_cur;
    logic [17:0]  r_stk;
    logic         r_stk_vld;
    logic [3:0]   r_idx;
    logic [255:0] r_tbl;
    logic [17:0]  r_vram_a;
    logic         r_vram_rd;
    logic         r_cmd_valid;
    logic [15:0]  r_copr;
    logic [15:0]  r_lopr;
    logic         r_cef;
    logic         r_bef;

    CMDTBL_t      w_tbl;
    CMDCTRL_t     w_ctrl_in;
    logic [15:0]  w_word;
    logic [7:0]   w_lsb;
    logic [17:0]  w_next;
    logic [17:0]  w_seq;
    logic         w_push;
    logic         w_pop;

`ifdef VDP1_CMD_WDOG_EN
    logic [15:0]  r_wdog;
`else
    logic         w_unused_wdog;
    assign w_unused_wdog = ^WDOG_MAX;
`endif

    assign w_tbl     = CMDTBL_t'(r_tbl);
    assign w_word    = VRAM_D & cmd_word_mask(r_idx);
    assign w_ctrl_in = CMDCTRL_t'(w_word);
    assign w_lsb     = {4'd15 - r_idx, 4'b0000};

    vdp1_cmd_addr u_addr (
        .i_jp      (w_tbl.ctrl.jp[1:0]),
        .i_link    (w_tbl.link),
        .i_cur     (r_cur),
        .i_stk     (r_stk),
        .i_stk_vld (r_stk_vld),
        .o_next    (w_next),
        .o_seq     (w_seq),
        .o_push    (w_push),
        .o_pop     (w_pop)
    );

    // Sequencer FSM: VRAM fetch handshake, dispatch handshake and flag upkeep.
    always_ff @(posedge CLK) begin
        // NOTE: the table register is ordinary state, so it is reset with everything else.
        if (!RST_N) begin
            r_state     <= SEQ_IDLE;
            r_cur       <= '0;
            r_stk       <= '0;
            r_stk_vld   <= 1'b0;
            r_idx       <= '0;
            r_tbl       <= '0;
            r_vram_a    <= '0;
            r_vram_rd   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_copr      <= '0;
            r_lopr      <= '0;
            r_cef       <= 1'b0;
            r_bef       <= 1'b0;
`ifdef VDP1_CMD_WDOG_EN
            r_wdog      <= '0;
`endif
        end else if (CE) begin
            if (START) begin
                r_bef       <= r_cef;
                r_cef       <= 1'b0;
                r_cur       <= '0;
                r_stk_vld   <= 1'b0;
                r_vram_rd   <= 1'b0;
                r_cmd_valid <= 1'b0;
                r_idx       <= '0;
                r_state     <= SEQ_FETCH_CTRL;
`ifdef VDP1_CMD_WDOG_EN
                r_wdog      <= '0;
`endif
            end else if (ABORT) begin
                r_vram_rd   <= 1'b0;
                r_cmd_valid <= 1'b0;
                r_state     <= SEQ_IDLE;
            end else begin
                case (r_state)
                    SEQ_FETCH_CTRL: begin
                        if (!r_vram_rd) begin
`ifdef VDP1_CMD_WDOG_EN
                            if (r_wdog == WDOG_MAX) begin
                                r_cef   <= 1'b1;
                                r_state <= SEQ_END;
                            end else begin
                                r_wdog    <= r_wdog + 16'd1;
                                r_vram_a  <= r_cur;
                                r_vram_rd <= 1'b1;
                                r_idx     <= 4'd0;
                                r_copr    <= r_cur[17:2];
                            end
`else
                            r_vram_a  <= r_cur;
                            r_vram_rd <= 1'b1;
                            r_idx     <= 4'd0;
                            r_copr    <= r_cur[17:2];
`endif
                        end else if (VRAM_RDY) begin
                            r_vram_rd          <= 1'b0;
                            r_tbl[w_lsb +: 16] <= w_word;
                            if (w_ctrl_in.end_f) begin
                                r_cef   <= 1'b1;
                                r_state <= SEQ_END;
                            end else if (w_ctrl_in.jp[2]) begin
                                r_idx   <= 4'd1;
                                r_state <= (w_ctrl_in.jp[1:0] == JP_ASSIGN ||
                                            w_ctrl_in.jp[1:0] == JP_CALL)
                                           ? SEQ_FETCH_LINK : SEQ_NEXT;
                            end else begin
                                r_idx   <= 4'd1;
                                r_state <= SEQ_FETCH_BODY;
                            end
                        end
                    end
                    SEQ_FETCH_LINK, SEQ_FETCH_BODY: begin
                        if (!r_vram_rd) begin
                            r_vram_a  <= r_cur + {14'd0, r_idx};
                            r_vram_rd <= 1'b1;
                        end else if (VRAM_RDY) begin
                            r_vram_rd          <= 1'b0;
                            r_tbl[w_lsb +: 16] <= w_word;
                            if (r_state == SEQ_FETCH_LINK) begin
                                r_state <= SEQ_NEXT;
                            end else if (r_idx == 4'd14) begin
                                r_cmd_valid <= cmd_is_drawable(w_tbl.ctrl.comm);
                                r_state     <= SEQ_DISPATCH;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                    end
                    SEQ_DISPATCH: begin
                        if (!r_cmd_valid) begin
                            r_state <= SEQ_NEXT;
                        end else if (CMD_ACK) begin
                            r_cmd_valid <= 1'b0;
                            r_lopr      <= r_copr;
                            r_state     <= SEQ_NEXT;
                        end
                    end
                    SEQ_NEXT: begin
                        r_cur <= w_next;
                        if (w_push) begin
                            r_stk     <= w_seq;
                            r_stk_vld <= 1'b1;
                        end else if (w_pop) begin
                            r_stk_vld <= 1'b0;
                        end
                        r_state <= SEQ_FETCH_CTRL;
                    end
                    SEQ_END:  r_state <= SEQ_IDLE;
                    default:  r_state <= SEQ_IDLE;
                endcase
            end
        end
    end

    assign VRAM_A    = r_vram_a;
    assign VRAM_RD   = r_vram_rd;
    assign CMD_VALID = r_cmd_valid;
    assign CMD_TBL   = r_tbl;
    assign COPR      = r_copr;
    assign LOPR      = r_lopr;
    assign CEF       = r_cef;
    assign BEF       = r_bef;
    assign BUSY      = (r_state != SEQ_IDLE);

endmodule

// File: tb/tb_vdp1_cmd_seq.sv
// Directed self-checking bench for vdp1_cmd_seq with a VRAM responder and
// a draw-engine responder. Build with VDP1_CMD_WDOG_EN to exercise the
// watchdog variant (WDOG_MAX is overridden to 8).
module tb_vdp1_cmd_seq;

    logic         CLK = 1'b0;
    logic         RST_N, CE, START, ABORT;
    logic [17:0]  VRAM_A;
    logic         VRAM_RD;
    logic [15:0]  VRAM_D;
    logic         VRAM_RDY;
    logic         CMD_VALID;
    logic [255:0] CMD_TBL;
    logic         CMD_ACK;
    logic [15:0]  COPR, LOPR;
    logic         CEF, BEF, BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]  vram [int];
    logic [17:0]  rd_log [$];
    int           allow     = -1;
    int           wait_cnt  = 0;
    logic [17:0]  req_a     = '0;
    int           ctrl0_cnt = 0;
    int           disp_cnt  = 0;
    int           ack_cnt   = 0;
    logic [255:0] saved_tbl = '0;

    vdp1_cmd_seq #(.WDOG_MAX(16'd8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE        (CE),
        .START     (START),
        .ABORT     (ABORT),
        .VRAM_A    (VRAM_A),
        .VRAM_RD   (VRAM_RD),
        .VRAM_D    (VRAM_D),
        .VRAM_RDY  (VRAM_RDY),
        .CMD_VALID (CMD_VALID),
        .CMD_TBL   (CMD_TBL),
        .CMD_ACK   (CMD_ACK),
        .COPR      (COPR),
        .LOPR      (LOPR),
        .CEF       (CEF),
        .BEF       (BEF),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        int k;
        k = int'(a);
        return vram.exists(k) ? vram[k] : 16'h0000;
    endfunction

    function automatic logic [17:0] log_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 18'h3FFFF;
    endfunction

    // VRAM responder: two-cycle latency, one-cycle RDY strobe, optional stall.
    initial begin
        VRAM_RDY = 1'b0;
        VRAM_D   = '0;
        forever begin
            @(negedge CLK);
            if (VRAM_RDY) begin
                VRAM_RDY = 1'b0;
            end else if (VRAM_RD) begin
                if (wait_cnt == 0) req_a = VRAM_A;
                wait_cnt++;
                if (wait_cnt >= 2 && allow != 0) begin
                    check("vram_a_stable", {46'd0, VRAM_A}, {46'd0, req_a});
                    VRAM_D   = mem_rd(VRAM_A);
                    VRAM_RDY = 1'b1;
                    rd_log.push_back(VRAM_A);
                    if (VRAM_A == 18'd0) ctrl0_cnt++;
                    wait_cnt = 0;
                    if (allow > 0) allow--;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Draw-engine responder: acknowledges each valid command after three cycles.
    initial begin
        CMD_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (CMD_ACK) begin
                CMD_ACK = 1'b0;
            end else if (CMD_VALID) begin
                ack_cnt++;
                if (ack_cnt == 3) begin
                    saved_tbl = CMD_TBL;
                    disp_cnt++;
                    CMD_ACK = 1'b1;
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic clear_mem();
        vram.delete();
        rd_log.delete();
        disp_cnt  = 0;
        ctrl0_cnt = 0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (BUSY && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check(tag, {63'd0, BUSY}, 64'd0);
    endtask

    initial begin
        RST_N = 1'b0; CE = 1'b1; START = 1'b0; ABORT = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_vram_rd",  {63'd0, VRAM_RD},   0);
        check("rst_vram_a",   {46'd0, VRAM_A},    0);
        check("rst_cmd_valid",{63'd0, CMD_VALID}, 0);
        check("rst_cmd_tbl",  {63'd0, (CMD_TBL == '0)}, 1);
        check("rst_copr",     {48'd0, COPR},      0);
        check("rst_lopr",     {48'd0, LOPR},      0);
        check("rst_flags",    {62'd0, CEF, BEF},  0);
        check("rst_busy",     {63'd0, BUSY},      0);
        RST_N = 1'b1;
        @(negedge CLK);

        // START is ignored while the clock enable is low.
        CE = 1'b0;
        pulse_start();
        repeat (3) @(negedge CLK);
        check("ce_low_busy", {63'd0, BUSY}, 0);
        check("ce_low_rd",   {63'd0, VRAM_RD}, 0);
        CE = 1'b1;
        @(negedge CLK);

        // 1: one NSPR, then an END table at word 16.
        clear_mem();
        vram[0]  = 16'h0000;
        for (int i = 1; i < 15; i++) vram[i] = 16'h1000 + 16'(i);
        vram[1]  = 16'h0013;
        vram[2]  = 16'hFFFF;
        vram[14] = 16'hABCF;
        vram[15] = 16'hFFFF;
        vram[16] = 16'h8000;
        pulse_start();
        check("t1_busy", {63'd0, BUSY}, 1);
        wait_idle("t1_done", 2000);
        check("t1_nreads", rd_log.size(), 16);
        for (int i = 0; i < 15; i++)
            check($sformatf("t1_addr%0d", i), {46'd0, log_at(i)}, i);
        check("t1_end_addr", {46'd0, log_at(15)}, 16);
        check("t1_disp",     disp_cnt, 1);
        check("t1_ctrl",     {48'd0, saved_tbl[255:240]}, 64'h0000);
        check("t1_link_msk", {48'd0, saved_tbl[239:224]}, 64'h0010);
        check("t1_pmod_msk", {48'd0, saved_tbl[223:208]}, 64'h9FFF);
        check("t1_grda_msk", {48'd0, saved_tbl[31:16]},   64'hABCC);
        check("t1_unused",   {48'd0, saved_tbl[15:0]},    64'h0000);
        check("t1_cef",      {63'd0, CEF}, 1);
        check("t1_bef",      {63'd0, BEF}, 0);
        check("t1_lopr",     {48'd0, LOPR}, 0);
        check("t1_copr",     {48'd0, COPR}, 4);

        // 2: JP=1 assign to link 0x0100 -> word 0x400.
        clear_mem();
        vram[0]     = 16'h1000;
        vram[1]     = 16'h0100;
        vram[18'h400] = 16'h8000;
        pulse_start();
        wait_idle("t2_done", 2000);
        check("t2_nreads",  rd_log.size(), 16);
        check("t2_jump",    {46'd0, log_at(15)}, 64'h400);
        check("t2_copr",    {48'd0, COPR}, 64'h0100);
        check("t2_bef",     {63'd0, BEF}, 1);
        check("t2_cef",     {63'd0, CEF}, 1);

        // 3: CALL to 0x100, RETURN to 16, RETURN with empty stack -> 32.
        clear_mem();
        vram[0]       = 16'h2000;
        vram[1]       = 16'h0040;
        vram[18'h100] = 16'h3000;
        vram[16]      = 16'h3000;
        vram[32]      = 16'h8000;
        pulse_start();
        wait_idle("t3_done", 3000);
        check("t3_nreads",  rd_log.size(), 46);
        check("t3_call",    {46'd0, log_at(15)}, 64'h100);
        check("t3_return",  {46'd0, log_at(30)}, 16);
        check("t3_fall",    {46'd0, log_at(45)}, 32);
        check("t3_disp",    disp_cnt, 3);
        check("t3_lopr",    {48'd0, LOPR}, 4);
        check("t3_copr",    {48'd0, COPR}, 8);

        // 4: skip with JP=4, then skip-assign with JP=5 to link 0x20 -> word 0x80.
        clear_mem();
        vram[0]       = 16'h4000;
        vram[16]      = 16'h5000;
        vram[17]      = 16'h0020;
        vram[18'h80]  = 16'h8000;
        pulse_start();
        wait_idle("t4_done", 1000);
        check("t4_nreads", rd_log.size(), 4);
        check("t4_a0",     {46'd0, log_at(0)}, 0);
        check("t4_a1",     {46'd0, log_at(1)}, 16);
        check("t4_a2",     {46'd0, log_at(2)}, 17);
        check("t4_a3",     {46'd0, log_at(3)}, 64'h80);
        check("t4_disp",   disp_cnt, 0);
        check("t4_lopr",   {48'd0, LOPR}, 4);
        check("t4_copr",   {48'd0, COPR}, 64'h20);

        // 5: ABORT while a body read is stalled, then restart.
        clear_mem();
        vram[0]  = 16'h0000;
        vram[16] = 16'h8000;
        allow = 3;
        pulse_start();
        repeat (30) @(negedge CLK);
        check("t5_stall_rd",  {63'd0, VRAM_RD}, 1);
        check("t5_stall_n",   rd_log.size(), 3);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("t5_abort_rd",   {63'd0, VRAM_RD}, 0);
        check("t5_abort_busy", {63'd0, BUSY}, 0);
        check("t5_abort_cef",  {63'd0, CEF}, 0);
        check("t5_abort_bef",  {63'd0, BEF}, 1);
        allow = -1;
        repeat (2) @(negedge CLK);
        rd_log.delete();
        pulse_start();
        wait_idle("t5_done", 2000);
        check("t5_restart_a", {46'd0, log_at(0)}, 0);
        check("t5_nreads",    rd_log.size(), 16);
        check("t5_bef",       {63'd0, BEF}, 0);
        check("t5_cef",       {63'd0, CEF}, 1);

        // 6: JP=1 self-loop.
        clear_mem();
        vram[0] = 16'h1000;
        vram[1] = 16'h0000;
        pulse_start();
`ifdef VDP1_CMD_WDOG_EN
        wait_idle("t6_wdog_done", 2000);
        check("t6_wdog_fetches", ctrl0_cnt, 8);
        check("t6_wdog_cef",     {63'd0, CEF}, 1);
`else
        begin
            int n;
            n = 0;
            while (ctrl0_cnt < 101 && n < 20000) begin
                @(negedge CLK);
                n++;
            end
        end
        check("t6_loop_fetches", {63'd0, (ctrl0_cnt >= 101)}, 1);
        check("t6_loop_busy",    {63'd0, BUSY}, 1);
        check("t6_loop_cef",     {63'd0, CEF}, 0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("t6_abort_busy",   {63'd0, BUSY}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
